// File: rtl/distributor_pkg.sv
// Shared types for the distributor: routing mode and output target encodings.
package distributor_pkg;

    typedef enum logic {
        ROUTE_DEST = 1'b0,
        ROUTE_RR   = 1'b1
    } route_mode_t;

    typedef enum logic {
        TARGET_A = 1'b0,
        TARGET_B = 1'b1
    } target_t;

    // Opposite output of t.
    function automatic target_t other_target(input target_t t);
        return (t == TARGET_A) ? TARGET_B : TARGET_A;
    endfunction

endpackage

// File: rtl/distributor_slot.sv
// One-entry registered output stage of the distributor.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         write i_data into the stage this edge
//   i_data         beat to load
//   i_ready        downstream consumer ready
//   o_valid        stage holds a beat
//   o_data         held beat
//   o_can_accept   stage can take a beat this cycle (empty or draining)
module distributor_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_accept
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Load wins over drain so a drain+load pair yields back-to-back beats.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            data_q  <= i_data;
        end else if (i_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_can_accept = !valid_q || i_ready;

endmodule

// File: rtl/distributor.sv
// Fans one valid/ready stream (X) out to two valid/ready streams (A, B).
// Beats are steered by i_x_dest (ROUTE_DEST) or by work-conserving
// round-robin (ROUTE_RR). Each output has a one-entry registered stage.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_x_data/i_x_dest/i_x_valid  input beat, destination, valid
//   o_x_ready                    input beat accepted (combinational)
//   o_a_data/o_a_valid/i_a_ready output A stream
//   o_b_data/o_b_valid/i_b_ready output B stream
module distributor
    import distributor_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter route_mode_t ROUTE_MODE = ROUTE_DEST
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_x_data,
    input  logic             i_x_dest,
    input  logic             i_x_valid,
    output logic             o_x_ready,
    output logic [WIDTH-1:0] o_a_data,
    output logic             o_a_valid,
    input  logic             i_a_ready,
    output logic [WIDTH-1:0] o_b_data,
    output logic             o_b_valid,
    input  logic             i_b_ready
);

    target_t rr_ptr;
    target_t target;
    logic    can_a;
    logic    can_b;
    logic    can_ptr;
    logic    can_other;
    logic    x_ready;
    logic    xfer;
    logic    load_a;
    logic    load_b;

    // Target selection; RR falls over to the other slot only when the
    // preferred one is blocked and the other is free.
    always_comb begin
        target    = TARGET_A;
        can_ptr   = (rr_ptr == TARGET_B) ? can_b : can_a;
        can_other = (rr_ptr == TARGET_B) ? can_a : can_b;
        if (ROUTE_MODE == ROUTE_DEST) begin
            target = target_t'(i_x_dest);
        end else begin
            target = rr_ptr;
            if (!can_ptr && can_other) begin
                target = other_target(rr_ptr);
            end
        end
    end

    // Ready never looks at i_x_valid.
    always_comb begin
        x_ready = 1'b0;
        if (!i_rst) begin
            x_ready = (target == TARGET_B) ? can_b : can_a;
        end
    end

    assign o_x_ready = x_ready;
    assign xfer      = i_x_valid && x_ready;
    assign load_a    = xfer && (target == TARGET_A);
    assign load_b    = xfer && (target == TARGET_B);

    // Pointer moves past the slot actually loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= TARGET_A;
        end else if (xfer) begin
            rr_ptr <= other_target(target);
        end
    end

    distributor_slot #(.WIDTH(WIDTH)) u_slot_a (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_a),
        .i_data       (i_x_data),
        .i_ready      (i_a_ready),
        .o_valid      (o_a_valid),
        .o_data       (o_a_data),
        .o_can_accept (can_a)
    );

    distributor_slot #(.WIDTH(WIDTH)) u_slot_b (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (load_b),
        .i_data       (i_x_data),
        .i_ready      (i_b_ready),
        .o_valid      (o_b_valid),
        .o_data       (o_b_data),
        .o_can_accept (can_b)
    );

endmodule

// File: tb/tb_distributor.sv
// Bench for distributor: one ROUTE_DEST and one ROUTE_RR instance share the
// same stimulus; each is tracked by a queue-based reference model plus
// directed checks for the individual scenarios.
module tb_distributor;
    import distributor_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x_data;
    logic         x_dest;
    logic         x_valid;
    logic         a_rdy;
    logic         b_rdy;

    // index 0: ROUTE_DEST instance, index 1: ROUTE_RR instance
    logic         x_ready [2];
    logic         a_valid [2];
    logic         b_valid [2];
    logic [W-1:0] a_data  [2];
    logic [W-1:0] b_data  [2];

    always #5 clk = ~clk;

    distributor #(.WIDTH(W), .ROUTE_MODE(ROUTE_DEST)) u_dest (
        .i_clk(clk), .i_rst(rst),
        .i_x_data(x_data), .i_x_dest(x_dest), .i_x_valid(x_valid),
        .o_x_ready(x_ready[0]),
        .o_a_data(a_data[0]), .o_a_valid(a_valid[0]), .i_a_ready(a_rdy),
        .o_b_data(b_data[0]), .o_b_valid(b_valid[0]), .i_b_ready(b_rdy)
    );

    distributor #(.WIDTH(W), .ROUTE_MODE(ROUTE_RR)) u_rr (
        .i_clk(clk), .i_rst(rst),
        .i_x_data(x_data), .i_x_dest(x_dest), .i_x_valid(x_valid),
        .o_x_ready(x_ready[1]),
        .o_a_data(a_data[1]), .o_a_valid(a_valid[1]), .i_a_ready(a_rdy),
        .o_b_data(b_data[1]), .o_b_valid(b_valid[1]), .i_b_ready(b_rdy)
    );

    // Reference model: per-output queue of beats the consumer has yet to take.
    logic [W-1:0] qa [2][$];
    logic [W-1:0] qb [2][$];
    bit           rr_pref_b;
    bit           xfer_s [2];
    bit           tgt_s  [2];
    int           acc [2];
    int           dlv [2];
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Predict ready and outputs from the queues, then compare.
    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            bit ca, cb, t, exp_rdy;
            ca = (qa[m].size() == 0) || a_rdy;
            cb = (qb[m].size() == 0) || b_rdy;
            if (m == 0) begin
                t = x_dest;
            end else begin
                t = rr_pref_b;
                if (!(t ? cb : ca) && (t ? ca : cb)) t = !t;
            end
            exp_rdy = !rst && (t ? cb : ca);
            chk($sformatf("x_ready[%0d]", m), W'(x_ready[m]), W'(exp_rdy));
            chk($sformatf("a_valid[%0d]", m), W'(a_valid[m]), W'(qa[m].size() != 0));
            if (qa[m].size() != 0) chk($sformatf("a_data[%0d]", m), a_data[m], qa[m][0]);
            chk($sformatf("b_valid[%0d]", m), W'(b_valid[m]), W'(qb[m].size() != 0));
            if (qb[m].size() != 0) chk($sformatf("b_data[%0d]", m), b_data[m], qb[m][0]);
            xfer_s[m] = x_valid && exp_rdy;
            tgt_s[m]  = t;
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                qa[m].delete();
                qb[m].delete();
                if (m == 1) rr_pref_b = 1'b0;
            end else begin
                if (qa[m].size() != 0 && a_rdy) begin
                    void'(qa[m].pop_front());
                    dlv[m]++;
                end
                if (qb[m].size() != 0 && b_rdy) begin
                    void'(qb[m].pop_front());
                    dlv[m]++;
                end
                if (xfer_s[m]) begin
                    acc[m]++;
                    if (tgt_s[m]) qb[m].push_back(x_data);
                    else          qa[m].push_back(x_data);
                    if (m == 1) rr_pref_b = !tgt_s[m];
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    logic [W-1:0] sd [3];
    bit           dd [3];
    int           cycles;

    initial begin
        sd = '{32'h11, 32'h22, 32'h33};
        dd = '{1'b0, 1'b1, 1'b0};
        acc = '{0, 0};
        dlv = '{0, 0};
        rr_pref_b = 1'b0;
        rst = 1'b1; x_valid = 1'b1; x_data = 32'hDEAD; x_dest = 1'b0;
        a_rdy = 1'b1; b_rdy = 1'b1;
        @(posedge clk); #1;

        // Reset held with a pending beat
        repeat (3) begin
            cyc();
            chk("rst_xrdy_dest", W'(x_ready[0]), '0);
            chk("rst_xrdy_rr",   W'(x_ready[1]), '0);
            chk("rst_avalid",    W'(a_valid[0]), '0);
            chk("rst_bvalid",    W'(b_valid[1]), '0);
            chk("rst_adata",     a_data[0], '0);
            chk("rst_bdata",     b_data[1], '0);
        end
        rst = 1'b0; x_data = 32'h1; x_dest = 1'b1;
        #1 chk("rr_first_rdy", W'(x_ready[1]), 1);
        cyc();
        chk("rr_first_avalid", W'(a_valid[1]), 1);
        chk("rr_first_adata",  a_data[1], 32'h1);
        chk("rr_first_bvalid", W'(b_valid[1]), 0);
        x_valid = 1'b0;
        cyc(); cyc();

        // Destination steering, both consumers ready
        for (int i = 0; i < 3; i++) begin
            x_valid = 1'b1; x_data = sd[i]; x_dest = dd[i];
            #1 chk("dest_rdy", W'(x_ready[0]), 1);
            cyc();
            chk("dest_valid", W'(dd[i] ? b_valid[0] : a_valid[0]), 1);
            chk("dest_data",  dd[i] ? b_data[0] : a_data[0], sd[i]);
        end
        x_valid = 1'b0;
        cyc();

        // Backpressure on A in destination mode
        a_rdy = 1'b0; x_valid = 1'b1; x_data = 32'hA0; x_dest = 1'b0;
        #1 chk("bp_rdy0", W'(x_ready[0]), 1);
        cyc();
        x_data = 32'hA1;
        #1 chk("bp_stall_rdy", W'(x_ready[0]), 0);
        chk("bp_hold_data", a_data[0], 32'hA0);
        cyc();
        chk("bp_hold_valid", W'(a_valid[0]), 1);
        chk("bp_hold_data2", a_data[0], 32'hA0);
        a_rdy = 1'b1;
        #1 chk("bp_release_rdy", W'(x_ready[0]), 1);
        cyc();
        chk("bp_b2b_valid", W'(a_valid[0]), 1);
        chk("bp_b2b_data",  a_data[0], 32'hA1);
        x_valid = 1'b0;
        cyc();
        chk("bp_drained", W'(a_valid[0]), 0);

        // Fresh reset so the round-robin pointer starts at A
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Round-robin alternation
        for (int k = 1; k <= 6; k++) begin
            x_valid = 1'b1; x_data = W'(k);
            cyc();
            if (k % 2 == 1) chk("rr_alt_a", a_data[1], W'(k));
            else            chk("rr_alt_b", b_data[1], W'(k));
        end
        x_valid = 1'b0;
        cyc();

        // Work-conserving fall-over while A is stalled
        a_rdy = 1'b0; b_rdy = 1'b1; x_valid = 1'b1; x_data = 32'h50;
        cyc();
        x_data = 32'h51;
        cyc();
        x_data = 32'h55;
        #1 chk("wc_rdy", W'(x_ready[1]), 1);
        cyc();
        chk("wc_b_valid", W'(b_valid[1]), 1);
        chk("wc_b_data",  b_data[1], 32'h55);
        chk("wc_a_hold",  a_data[1], 32'h50);
        b_rdy = 1'b0; x_data = 32'h56;
        #1 chk("wc_stall_rdy", W'(x_ready[1]), 0);
        cyc();
        a_rdy = 1'b1; b_rdy = 1'b1;
        #1 chk("wc_ptr_rdy", W'(x_ready[1]), 1);
        cyc();
        chk("wc_ptr_a", a_data[1], 32'h56);
        x_valid = 1'b0;
        cyc(); cyc();

        // Random traffic against the model
        cycles = 0;
        while ((acc[0] < 10000 || acc[1] < 10000) && cycles < 40000) begin
            x_valid = ($urandom % 4) != 0;
            x_data  = $urandom;
            x_dest  = $urandom % 2;
            a_rdy   = ($urandom % 4) != 0;
            b_rdy   = ($urandom % 4) != 0;
            cyc();
            cycles++;
        end
        chk("rand_budget", W'(cycles < 40000), 1);
        x_valid = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
        repeat (3) cyc();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("left_a[%0d]", m), W'(qa[m].size()), 0);
            chk($sformatf("left_b[%0d]", m), W'(qb[m].size()), 0);
            chk($sformatf("count[%0d]", m), W'(dlv[m]), W'(acc[m]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/distributor.md
Name: distributor

Overview:
- Splits one valid/ready input stream (X) into two valid/ready output streams (A, B). It is the fan-out counterpart of the two-input arbiter and sits in the example design on the producer side of a pair of consumers.
- Each beat is steered by an explicit destination bit or by work-conserving round-robin.
- Each output has a one-entry registered stage, so outputs are registered with 1-cycle latency and sustain full throughput.

Parameters:
- WIDTH, 32, data width of all streams.
- ROUTE_MODE, ROUTE_DEST, ROUTE_DEST = steer by i_x_dest; ROUTE_RR = work-conserving round-robin, i_x_dest ignored.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_x_data  input  WIDTH  input beat data.
- i_x_dest  input  1  destination; 0 = A, 1 = B. ROUTE_DEST only.
- i_x_valid  input  1  input beat valid.
- o_x_ready  output  1  input beat accepted this cycle when high with i_x_valid.
- o_a_data  output  WIDTH  A data.
- o_a_valid  output  1  A valid.
- i_a_ready  input  1  A consumer ready.
- o_b_data  output  WIDTH  B data.
- o_b_valid  output  1  B valid.
- i_b_ready  input  1  B consumer ready.

Behaviour:
- Reset (synchronous, i_rst high at an edge):
  - o_a_valid = o_b_valid = 0; o_a_data = o_b_data = 0; RR pointer = A.
  - o_x_ready is forced 0 while i_rst is high.
  - Beats held at reset are discarded, with no completion.
- Slot can_accept: can_accept_a = !o_a_valid || i_a_ready; can_accept_b is the same for B.
- Target selection:
  - ROUTE_DEST: target = i_x_dest.
  - ROUTE_RR: target = pointer, unless the pointer's slot cannot accept and the other slot can; then target = the other slot.
- o_x_ready = can_accept(target). It is combinational from slot state, downstream ready, i_x_dest and the pointer. It must not depend on i_x_valid.
- Transfer: i_x_valid && o_x_ready. The beat loads the target slot at the edge and appears on the output the next cycle (latency 1).
- Slot update, in priority order:
  - load → valid = 1, data = new beat;
  - else ready && valid → valid = 0;
  - else hold.
  - Drain and load in the same cycle gives back-to-back beats: valid stays 1 and data is replaced.
- While o_*_valid is high and ready is low, the output data and valid are held stable (valid/ready rule).
- A stalled output never blocks the other output in either mode. In ROUTE_DEST, a beat for a stalled output does block X (no reordering).
- RR pointer: updates only on a transfer, to the opposite of the slot actually loaded. Alternation A, B, A, B when both outputs are free.
- Ordering is preserved per output. No beat is dropped or duplicated.
- Throughput: 1 beat/cycle at X when the targets accept.

Decomposition:
- Shared package distributor_pkg:
  - route_mode_t enum {ROUTE_DEST, ROUTE_RR};
  - target_t enum {TARGET_A = 0, TARGET_B = 1}.
- One sub-module, distributor_slot (WIDTH): one-entry register with i_load, i_data, i_ready → o_valid, o_data, o_can_accept. Instantiated twice.

Test Plan:
- Reset: hold i_rst 3 cycles with i_x_valid = 1 → o_x_ready = 0, both outputs valid = 0 and data = 0; after release the first beat goes to A (RR).
- DEST steering, both ready = 1: beats 0x11 (dest 0), 0x22 (dest 1), 0x33 (dest 0) on consecutive cycles → A receives 0x11 then 0x33, B receives 0x22, each one cycle after acceptance; o_x_ready stays 1.
- Backpressure (DEST): i_a_ready = 0, send 0xA0 and then 0xA1 to A → 0xA0 held on A and o_x_ready drops. Raise i_a_ready → 0xA0 completes and 0xA1 loads in the same cycle, then 0xA1 appears with no gap.
- RR alternation, both ready: beats 1..6 → A gets 1, 3, 5; B gets 2, 4, 6.
- RR work-conserving: o_a_valid = 1 with i_a_ready = 0 and pointer = A; send 0x55 → 0x55 goes to B and the pointer moves to A. The next beat targets A and stalls (o_x_ready = 0).
- Random mode: random valid/ready on all ports, 10k beats → the per-output scoreboard shows each beat exactly once, in order, and stable while stalled.
